branch_redirect: RTL and testbench

Execute-to-fetch branch resolution unit. Consumes the Execute-stage compare result `jump_state_pre` together with jump/branch qualifiers, computes the control-transfer target, and owns the fetch program counter. On a taken transfer it redirects the PC, squashes the wrong-path instructions in IF/DE and DE/EX for a fixed number of cycles, and reports misaligned targets as a one-cycle trap pulse.

---
 rtl/branch_redirect_if.sv | 46 ++++
 rtl/branch_redirect.sv | 108 ++++++++++
 tb/tb_branch_redirect.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_if.sv
// rtl/branch_redirect_if.sv - Execute-to-fetch redirect bundle
//
// Purpose: groups the Execute-stage control-transfer inputs and the fetch /
// squash / trap outputs of branch_redirect into one bundle.
// Ports (signals):
//   stall                       global pipeline stall
//   br_valid_ex/jal_ex/jalr_ex  one-hot transfer qualifiers from Execute
//   jump_state_pre              branch compare result
//   curr_pc_ex/imm_ex/rs1data_ex  target operands
//   pc_if                       fetch PC
//   flush_if_de/flush_de_ex     wrong-path squash
//   trap_misalign/trap_tval     misaligned-target trap pulse and value
//   redirect_cnt                performed redirects
// Modports: master drives the Execute side, slave is the redirect unit.
interface branch_redirect_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            br_valid_ex;
  logic            jal_ex;
  logic            jalr_ex;
  logic            jump_state_pre;
  logic [XLEN-1:0] curr_pc_ex;
  logic [XLEN-1:0] imm_ex;
  logic [XLEN-1:0] rs1data_ex;
  logic [XLEN-1:0] pc_if;
  logic            flush_if_de;
  logic            flush_de_ex;
  logic            trap_misalign;
  logic [XLEN-1:0] trap_tval;
  logic [31:0]     redirect_cnt;

  modport master (
    output stall, br_valid_ex, jal_ex, jalr_ex, jump_state_pre,
           curr_pc_ex, imm_ex, rs1data_ex,
    input  pc_if, flush_if_de, flush_de_ex, trap_misalign, trap_tval,
           redirect_cnt
  );

  modport slave (
    input  stall, br_valid_ex, jal_ex, jalr_ex, jump_state_pre,
           curr_pc_ex, imm_ex, rs1data_ex,
    output pc_if, flush_if_de, flush_de_ex, trap_misalign, trap_tval,
           redirect_cnt
  );
endinterface

// File: rtl/branch_redirect.sv
// rtl/branch_redirect.sv - Execute-to-fetch branch resolution and fetch PC owner
//
// Purpose: resolves jumps/branches from Execute, owns the fetch PC, squashes
// the wrong path for FLUSH_CYCLES unstalled cycles after a redirect, and
// raises a one-cycle trap for targets with bit 1 set.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    branch_redirect_if.slave (Execute inputs, fetch/flush/trap outputs)
module branch_redirect #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_redirect_if.slave  bus
);

  typedef enum logic [1:0] {S_RUN, S_HOLD, S_FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, tval_q, pend_target;
  logic [XLEN-1:0] sum_br, sum_jalr, target, eff_target;
  logic [2:0]      cnt_q;
  logic [31:0]     rcnt_q;
  logic            trap_q, pend_mis;
  logic            req, mis, eff_mis, act, do_redirect, do_trap, load_pend;

  // Target resolution and action decode. In HOLD the captured target is used
  // so that the Execute inputs are free to change while the pipe is stalled.
  always_comb begin
    sum_br      = bus.curr_pc_ex + bus.imm_ex;
    sum_jalr    = bus.rs1data_ex + bus.imm_ex;
    target      = bus.jalr_ex ? {sum_jalr[XLEN-1:1], 1'b0} : sum_br;
    mis         = target[1];
    req         = (bus.br_valid_ex & bus.jump_state_pre) | bus.jal_ex | bus.jalr_ex;
    eff_target  = (state_q == S_HOLD) ? pend_target : target;
    eff_mis     = (state_q == S_HOLD) ? pend_mis : mis;
    act         = !bus.stall && (((state_q == S_RUN) && req) || (state_q == S_HOLD));
    do_redirect = act && !eff_mis;
    do_trap     = act && eff_mis;
    load_pend   = (state_q == S_RUN) && req && bus.stall;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (load_pend)        state_d = S_HOLD;
        else if (do_redirect) state_d = S_FLUSH;
      end
      S_HOLD: begin
        if (!bus.stall)       state_d = do_redirect ? S_FLUSH : S_RUN;
      end
      S_FLUSH: begin
        if (!bus.stall && (cnt_q == 3'd1)) state_d = S_RUN;
      end
      default:                state_d = S_RUN;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_VECTOR;
      cnt_q       <= 3'd0;
      rcnt_q      <= 32'd0;
      trap_q      <= 1'b0;
      tval_q      <= '0;
      pend_target <= '0;
      pend_mis    <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= do_trap;
      if (do_trap) tval_q <= eff_target;
      if (load_pend) begin
        pend_target <= target;
        pend_mis    <= mis;
      end
      if ((state_q == S_FLUSH) && !bus.stall) cnt_q <= cnt_q - 3'd1;
      if (do_redirect) begin
        pc_q   <= eff_target;
        rcnt_q <= rcnt_q + 32'd1;
        cnt_q  <= FLUSH_LOAD;
      end else if (!bus.stall) begin
        // Sequential fetch continues on the wrong path during FLUSH and
        // past a trapped (misaligned) transfer.
        pc_q <= pc_q + XLEN'(4);
      end
    end
  end

  // Outputs: flushes decode the registered FLUSH state
  always_comb begin
    bus.flush_if_de   = (state_q == S_FLUSH);
    bus.flush_de_ex   = (state_q == S_FLUSH);
    bus.pc_if         = pc_q;
    bus.trap_misalign = trap_q;
    bus.trap_tval     = tval_q;
    bus.redirect_cnt  = rcnt_q;
  end

endmodule

// File: tb/tb_branch_redirect.sv
// tb/tb_branch_redirect.sv - self-checking bench for branch_redirect
module tb_branch_redirect;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        trap;
    logic [31:0] tval;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic        st, br, jal, jalr, jsp;
    logic [31:0] cpc, imm, rs1;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[28];

  branch_redirect_if #(.XLEN(32)) bus ();

  branch_redirect #(
    .XLEN(32), .RESET_VECTOR(32'h0000_0000), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n)
      assert ($onehot0({bus.br_valid_ex, bus.jal_ex, bus.jalr_ex}))
      else $error("illegal qualifier combination");

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic st, br, jal, jalr, jsp,
                              input logic [31:0] cpc, imm, rs1, pc,
                              input logic fl, tr,
                              input logic [31:0] tval, cnt);
    vec_t v;
    v.st = st; v.br = br; v.jal = jal; v.jalr = jalr; v.jsp = jsp;
    v.cpc = cpc; v.imm = imm; v.rs1 = rs1;
    v.e.pc = pc; v.e.fl = fl; v.e.trap = tr; v.e.tval = tval; v.e.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sample(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " pc_if"},         bus.pc_if,                 e.pc);
    chk({tag, " flush_if_de"},   32'(bus.flush_if_de),      32'(e.fl));
    chk({tag, " flush_de_ex"},   32'(bus.flush_de_ex),      32'(e.fl));
    chk({tag, " trap_misalign"}, 32'(bus.trap_misalign),    32'(e.trap));
    chk({tag, " trap_tval"},     bus.trap_tval,             e.tval);
    chk({tag, " redirect_cnt"},  bus.redirect_cnt,          e.cnt);
  endtask

  task automatic drive(input vec_t v);
    bus.stall          = v.st;
    bus.br_valid_ex    = v.br;
    bus.jal_ex         = v.jal;
    bus.jalr_ex        = v.jalr;
    bus.jump_state_pre = v.jsp;
    bus.curr_pc_ex     = v.cpc;
    bus.imm_ex         = v.imm;
    bus.rs1data_ex     = v.rs1;
    sb.push_back(v.e);
  endtask

  task automatic expect_now(input logic [31:0] pc, input logic fl, tr,
                            input logic [31:0] tval, cnt);
    exp_t e;
    e.pc = pc; e.fl = fl; e.trap = tr; e.tval = tval; e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    //                 st br jal jalr jsp cpc            imm            rs1            | pc            fl tr tval           cnt
    vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h4,         0, 0, 32'h0,      0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h8,         0, 0, 32'h0,      0);
    vecs[2]  = mk(0, 1, 0, 0, 1, 32'h100,       32'h40,  32'h0,      32'h140,       1, 0, 32'h0,      1);
    vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h144,       1, 0, 32'h0,      1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h148,       0, 0, 32'h0,      1);
    vecs[5]  = mk(0, 1, 0, 0, 0, 32'h200,       32'h40,  32'h0,      32'h14C,       0, 0, 32'h0,      1);
    vecs[6]  = mk(0, 0, 0, 1, 0, 32'h0,         32'h4,   32'h1003,   32'h150,       0, 1, 32'h1006,   1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h154,       0, 0, 32'h1006,   1);
    vecs[8]  = mk(0, 0, 0, 1, 0, 32'h0,         32'h4,   32'h1001,   32'h1004,      1, 0, 32'h1006,   2);
    vecs[9]  = mk(0, 1, 0, 0, 1, 32'h300,       32'h10,  32'h0,      32'h1008,      1, 0, 32'h1006,   2);
    vecs[10] = mk(0, 1, 0, 0, 1, 32'h300,       32'h10,  32'h0,      32'h100C,      0, 0, 32'h1006,   2);
    vecs[11] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h1010,      0, 0, 32'h1006,   2);
    vecs[12] = mk(1, 0, 1, 0, 0, 32'h700,       32'h100, 32'h0,      32'h1010,      0, 0, 32'h1006,   2);
    vecs[13] = mk(1, 0, 1, 0, 0, 32'h700,       32'h100, 32'h0,      32'h1010,      0, 0, 32'h1006,   2);
    vecs[14] = mk(1, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h1010,      0, 0, 32'h1006,   2);
    vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h800,       1, 0, 32'h1006,   3);
    vecs[16] = mk(1, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h800,       1, 0, 32'h1006,   3);
    vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h804,       1, 0, 32'h1006,   3);
    vecs[18] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h808,       0, 0, 32'h1006,   3);
    vecs[19] = mk(1, 1, 0, 0, 1, 32'h10,        32'h2,   32'h0,      32'h808,       0, 0, 32'h1006,   3);
    vecs[20] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h80C,       0, 1, 32'h12,     3);
    vecs[21] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h810,       0, 0, 32'h12,     3);
    vecs[22] = mk(1, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h810,       0, 0, 32'h12,     3);
    vecs[23] = mk(0, 0, 1, 0, 0, 32'hFFFF_FF00, 32'hF8,  32'h0,      32'hFFFF_FFF8, 1, 0, 32'h12,     4);
    vecs[24] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'hFFFF_FFFC, 1, 0, 32'h12,     4);
    vecs[25] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h0,         0, 0, 32'h12,     4);
    vecs[26] = mk(0, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h20,  32'h0,      32'h10,        1, 0, 32'h12,     5);
    vecs[27] = mk(0, 0, 0, 0, 0, 32'h0,         32'h0,   32'h0,      32'h14,        1, 0, 32'h12,     5);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1 sample("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1 sample($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Asynchronous reset while in FLUSH, then sequential fetch restarts.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    void'(sb.pop_back());
    #2 rst_n = 1'b0;
    expect_now(32'h0, 0, 0, 32'h0, 32'h0);
    #1 sample("async_reset");
    @(posedge clk);
    expect_now(32'h0, 0, 0, 32'h0, 32'h0);
    #1 sample("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    expect_now(32'h4, 0, 0, 32'h0, 32'h0);
    #1 sample("post_reset1");
    @(posedge clk);
    expect_now(32'h8, 0, 0, 32'h0, 32'h0);
    #1 sample("post_reset2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
